// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing controller for the 5-stage pipeline.
// Drives load enables and bubble flushes for the PC, IF/ID, ID/EX and EX/MEM
// registers. It resolves three hazards: data-memory wait states, taken
// redirects resolved in EX, and load-use dependencies. It also keeps a
// memory-timeout watchdog and saturating stall/flush counters.
//
// Ports
//   clock, reset         core clock (rising edge), async active-low reset
//   ID_rs/ID_rt/ID_uses_rt       source operands of the ID instruction
//   EX_RegWrite/EX_MemtoReg/EX_WriteReg/EX_PCSrc  EX instruction info
//   ME_MemWrite/ME_MemtoReg      ME instruction memory access kind
//   dmem_ready           data memory completes the access this cycle
//   dmem_req             data memory access request
//   PC_en..EXME_en       pipeline register load enables
//   IFID_flush/IDEX_flush  load a bubble instead of data
//   mem_err              sticky memory-timeout flag
//   wait_state           controller is in MEM_WAIT
//   stall_cycles         saturating count of cycles with PC_en low
//   flush_count          saturating count of applied redirects
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             EX_RegWrite,
  input  logic             EX_MemtoReg,
  input  logic [4:0]       EX_WriteReg,
  input  logic [2:0]       EX_PCSrc,
  input  logic             ME_MemWrite,
  input  logic             ME_MemtoReg,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IDEX_en,
  output logic             EXME_en,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             mem_err,
  output logic             wait_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [7:0]       flush_count
);

  localparam int unsigned WCNT_W = 8;
  localparam int unsigned FCNT_W = 8;

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  STALL_MAX  = '1;
  localparam logic [FCNT_W-1:0] FLUSH_MAX  = '1;

  logic [0:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [FCNT_W-1:0] flush_q, flush_d;

  logic me_acc;
  logic lu;
  logic redir;
  logic redir_take;

  // Hazard detection on the current ID/EX/ME contents.
  assign me_acc = ME_MemWrite | ME_MemtoReg;
  assign lu     = EX_MemtoReg & EX_RegWrite & (EX_WriteReg != 5'd0) &
                  ((EX_WriteReg == ID_rs) | (ID_uses_rt & (EX_WriteReg == ID_rt)));
  assign redir  = (EX_PCSrc != 3'd0);

  // State register and watchdog/counter state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  // Next-state and pipeline control decode.
  always_comb begin
    logic eval;
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    mem_err_d  = mem_err_q;
    dmem_req   = 1'b0;
    PC_en      = 1'b0;
    IFID_en    = 1'b0;
    IDEX_en    = 1'b0;
    EXME_en    = 1'b0;
    IFID_flush = 1'b0;
    IDEX_flush = 1'b0;
    redir_take = 1'b0;
    eval       = 1'b0;

    case (state_q)
      RUN: begin
        dmem_req = me_acc;
        if (me_acc && !dmem_ready) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end else begin
          eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (!dmem_ready && (wcnt_q < WCNT_LIMIT)) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end else begin
          // Release: the deferred redirect/load-use is evaluated now.
          eval    = 1'b1;
          state_d = RUN;
          wcnt_d  = '0;
          if (!dmem_ready) begin
            mem_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase

    // Hazard priority once no memory stall applies: redirect, load-use, normal.
    if (eval) begin
      if (redir) begin
        PC_en      = 1'b1;
        IFID_en    = 1'b1;
        IDEX_en    = 1'b1;
        EXME_en    = 1'b1;
        IFID_flush = 1'b1;
        IDEX_flush = 1'b1;
        redir_take = 1'b1;
      end else if (lu) begin
        IDEX_en    = 1'b1;
        IDEX_flush = 1'b1;
        EXME_en    = 1'b1;
      end else begin
        PC_en      = 1'b1;
        IFID_en    = 1'b1;
        IDEX_en    = 1'b1;
        EXME_en    = 1'b1;
      end
    end

    // Controls are quiet while reset is held.
    if (!reset) begin
      dmem_req   = 1'b0;
      PC_en      = 1'b0;
      IFID_en    = 1'b0;
      IDEX_en    = 1'b0;
      EXME_en    = 1'b0;
      IFID_flush = 1'b0;
      IDEX_flush = 1'b0;
      redir_take = 1'b0;
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!PC_en && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (redir_take && (flush_q != FLUSH_MAX)) begin
      flush_d = flush_q + FCNT_W'(1);
    end
  end

  assign wait_state   = (state_q == MEM_WAIT);
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle expectation queue.
module tb_pipe_hazard_ctrl;

  logic        clock;
  logic        reset;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_uses_rt;
  logic        EX_RegWrite;
  logic        EX_MemtoReg;
  logic [4:0]  EX_WriteReg;
  logic [2:0]  EX_PCSrc;
  logic        ME_MemWrite;
  logic        ME_MemtoReg;
  logic        dmem_ready;
  logic        dmem_req;
  logic        PC_en;
  logic        IFID_en;
  logic        IDEX_en;
  logic        EXME_en;
  logic        IFID_flush;
  logic        IDEX_flush;
  logic        mem_err;
  logic        wait_state;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg),
    .EX_WriteReg(EX_WriteReg), .EX_PCSrc(EX_PCSrc),
    .ME_MemWrite(ME_MemWrite), .ME_MemtoReg(ME_MemtoReg),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en), .EXME_en(EXME_en),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .mem_err(mem_err), .wait_state(wait_state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // {dmem_req, PC_en, IFID_en, IDEX_en, EXME_en, IFID_flush, IDEX_flush}
  localparam logic [6:0] C_ZERO    = 7'b0_0000_00;
  localparam logic [6:0] C_NORM    = 7'b0_1111_00;
  localparam logic [6:0] C_NORMA   = 7'b1_1111_00;
  localparam logic [6:0] C_STALLA  = 7'b1_0000_00;
  localparam logic [6:0] C_LU      = 7'b0_0011_01;
  localparam logic [6:0] C_LUA     = 7'b1_0011_01;
  localparam logic [6:0] C_REDIR   = 7'b0_1111_11;
  localparam logic [6:0] C_REDIRA  = 7'b1_1111_11;

  typedef struct packed {
    logic [15:0] tag;
    logic [6:0]  ctl;
    logic        ws;
    logic        err;
    logic [15:0] stall;
    logic [7:0]  flush;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare the DUT against the oldest expectation mid-cycle.
  always @(negedge clock) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert ({dmem_req, PC_en, IFID_en, IDEX_en, EXME_en, IFID_flush, IDEX_flush} === e.ctl)
        else begin
          errors++;
          $error("FAIL ctl step %0d: got %b want %b", e.tag,
                 {dmem_req, PC_en, IFID_en, IDEX_en, EXME_en, IFID_flush, IDEX_flush}, e.ctl);
        end
      checks++;
      assert (wait_state === e.ws)
        else begin errors++; $error("FAIL wait_state step %0d: got %b want %b", e.tag, wait_state, e.ws); end
      checks++;
      assert (mem_err === e.err)
        else begin errors++; $error("FAIL mem_err step %0d: got %b want %b", e.tag, mem_err, e.err); end
      checks++;
      assert (stall_cycles === e.stall)
        else begin errors++; $error("FAIL stall_cycles step %0d: got %0d want %0d", e.tag, stall_cycles, e.stall); end
      checks++;
      assert (flush_count === e.flush)
        else begin errors++; $error("FAIL flush_count step %0d: got %0d want %0d", e.tag, flush_count, e.flush); end
    end
  end

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic ex_rw, input logic ex_ld, input logic [4:0] ex_wr,
                        input logic [2:0] pcsrc, input logic me_st, input logic me_ld,
                        input logic rdy);
    ID_rs = rs; ID_rt = rt; ID_uses_rt = uses_rt;
    EX_RegWrite = ex_rw; EX_MemtoReg = ex_ld; EX_WriteReg = ex_wr; EX_PCSrc = pcsrc;
    ME_MemWrite = me_st; ME_MemtoReg = me_ld; dmem_ready = rdy;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic step(input int tag, input logic [6:0] ctl, input logic ws, input logic err,
                      input logic [15:0] stall, input logic [7:0] flush);
    exp_t x;
    x.tag = 16'(tag); x.ctl = ctl; x.ws = ws; x.err = err; x.stall = stall; x.flush = flush;
    sb.push_back(x);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int f;
    reset = 1'b0;
    idle();
    @(posedge clock);
    #1;

    // Reset: everything quiet even with a pending memory access.
    step(1, C_ZERO, 0, 0, 16'd0, 8'd0);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    step(2, C_ZERO, 0, 0, 16'd0, 8'd0);
    reset = 1'b1;

    // Zero-wait load access.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b1);
    step(3, C_NORMA, 0, 0, 16'd0, 8'd0);
    idle();
    step(4, C_NORM, 0, 0, 16'd0, 8'd0);

    // Load-use on rs costs one bubble.
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 3'd0, 1'b0, 1'b0, 1'b0);
    step(5, C_LU, 0, 0, 16'd0, 8'd0);
    idle();
    step(6, C_NORM, 0, 0, 16'd1, 8'd0);
    // Destination r0 never creates a dependency.
    set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(7, C_NORM, 0, 0, 16'd1, 8'd0);
    // Dependency through rt only when rt is read.
    set_in(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 3'd0, 1'b0, 1'b0, 1'b0);
    step(8, C_LU, 0, 0, 16'd1, 8'd0);
    set_in(5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 3'd0, 1'b0, 1'b0, 1'b0);
    step(9, C_NORM, 0, 0, 16'd2, 8'd0);
    // A load that does not write a register is harmless.
    set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 3'd0, 1'b0, 1'b0, 1'b0);
    step(10, C_NORM, 0, 0, 16'd2, 8'd0);

    // Store with three wait cycles, ready on the fourth request cycle.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    step(11, C_STALLA, 0, 0, 16'd2, 8'd0);
    step(12, C_STALLA, 1, 0, 16'd3, 8'd0);
    step(13, C_STALLA, 1, 0, 16'd4, 8'd0);
    dmem_ready = 1'b1;
    step(14, C_NORMA, 1, 0, 16'd5, 8'd0);
    idle();
    step(15, C_NORM, 0, 0, 16'd5, 8'd0);

    // Redirect wins over a simultaneous load-use.
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 3'b010, 1'b0, 1'b0, 1'b0);
    step(16, C_REDIR, 0, 0, 16'd5, 8'd0);
    idle();
    step(17, C_NORM, 0, 0, 16'd5, 8'd1);

    // Memory never ready: TIMEOUT=4 frozen cycles, then forced release.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    step(18, C_STALLA, 0, 0, 16'd5, 8'd1);
    step(19, C_STALLA, 1, 0, 16'd6, 8'd1);
    step(20, C_STALLA, 1, 0, 16'd7, 8'd1);
    step(21, C_STALLA, 1, 0, 16'd8, 8'd1);
    step(22, C_NORMA, 1, 0, 16'd9, 8'd1);
    idle();
    step(23, C_NORM, 0, 1, 16'd9, 8'd1);
    // A later good access leaves mem_err set.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b1);
    step(24, C_NORMA, 0, 1, 16'd9, 8'd1);
    idle();
    step(25, C_NORM, 0, 1, 16'd9, 8'd1);

    // Redirect held through a two-cycle memory wait is applied at release.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0);
    step(26, C_STALLA, 0, 1, 16'd9, 8'd1);
    step(27, C_STALLA, 1, 1, 16'd10, 8'd1);
    dmem_ready = 1'b1;
    step(28, C_REDIRA, 1, 1, 16'd11, 8'd1);
    idle();
    step(29, C_NORM, 0, 1, 16'd11, 8'd2);

    // Load-use held through a one-cycle memory wait is applied at release.
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 3'd0, 1'b0, 1'b1, 1'b0);
    step(30, C_STALLA, 0, 1, 16'd11, 8'd2);
    dmem_ready = 1'b1;
    step(31, C_LUA, 1, 1, 16'd12, 8'd2);
    idle();
    step(32, C_NORM, 0, 1, 16'd13, 8'd2);

    // flush_count saturates at 255.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'b100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) begin
      f = 2 + i;
      if (f > 255) f = 255;
      step(100 + i, C_REDIR, 0, 1, 16'd13, 8'(f));
    end
    idle();
    step(33, C_NORM, 0, 1, 16'd13, 8'd255);

    // Reset asserted mid-MEM_WAIT takes effect without a clock edge.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    step(34, C_STALLA, 0, 1, 16'd13, 8'd255);
    step(35, C_STALLA, 1, 1, 16'd14, 8'd255);
    reset = 1'b0;
    step(36, C_ZERO, 0, 0, 16'd0, 8'd0);
    step(37, C_ZERO, 0, 0, 16'd0, 8'd0);
    reset = 1'b1;
    idle();
    step(38, C_NORM, 0, 0, 16'd0, 8'd0);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    step(39, C_NORMA, 0, 0, 16'd0, 8'd0);
    idle();

    @(negedge clock);
    #1;
    checks++;
    assert (sb.size() == 0)
      else begin errors++; $error("FAIL drain: got %0d pending want 0", sb.size()); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core: it drives enable/flush for PC, IF/ID, ID/EX and EX/MEM registers. It resolves three hazards: data-memory wait states (req/ready handshake), taken control transfers resolved in EX, and load-use dependencies. It also keeps a memory-timeout watchdog and saturating stall/flush performance counters. It sits beside the pipeline registers and is the only source of their enable/flush controls.

## Interface
- TIMEOUT, 16, max MEM_WAIT cycles before forced release (legal 2..255)
- CNT_W, 16, width of stall_cycles counter
- clock  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ID_rs  in  5  source reg 1 of instruction in ID
- ID_rt  in  5  source reg 2 of instruction in ID
- ID_uses_rt  in  1  ID instruction reads ID_rt
- EX_RegWrite  in  1  EX instruction writes a register
- EX_MemtoReg  in  1  EX instruction is a load
- EX_WriteReg  in  5  EX destination register
- EX_PCSrc  in  3  nonzero = taken redirect resolved in EX
- ME_MemWrite  in  1  ME instruction is a store
- ME_MemtoReg  in  1  ME instruction is a load
- dmem_ready  in  1  data memory completes the current access this cycle
- dmem_req  out  1  data memory access request
- PC_en, IFID_en, IDEX_en, EXME_en  out  1 each  register load enables
- IFID_flush, IDEX_flush  out  1 each  load bubble (all-zero controls) instead of data
- mem_err  out  1  sticky: a memory access hit TIMEOUT
- wait_state  out  1  FSM is in MEM_WAIT
- stall_cycles  out  CNT_W  saturating count of cycles with PC_en=0
- flush_count  out  8  saturating count of redirects

## Operation
- Decided: one clock; reset is asynchronous and active-low (ports clock, reset).
- Define me_acc = ME_MemWrite | ME_MemtoReg.
- Define lu = EX_MemtoReg & EX_RegWrite & (EX_WriteReg!=0) & ((EX_WriteReg==ID_rs) | (ID_uses_rt & EX_WriteReg==ID_rt)).
- Define redir = (EX_PCSrc!=0).
- FSM states: RUN, MEM_WAIT. Wait counter wcnt is 8 bits.
- RUN: dmem_req = me_acc.
  - me_acc & !dmem_ready: all four enables 0, no flushes, next = MEM_WAIT, wcnt <= 1.
  - Otherwise, priority is redir > lu > normal.
  - redir: all enables 1, IFID_flush=1, IDEX_flush=1, flush_count++.
  - lu: PC_en=0, IFID_en=0, IDEX_en=1 with IDEX_flush=1, EXME_en=1.
  - normal: all enables 1, no flushes.
- MEM_WAIT: dmem_req=1.
  - !dmem_ready & wcnt<TIMEOUT: all enables 0, wcnt++.
  - dmem_ready, or wcnt==TIMEOUT: release. The cycle is evaluated exactly as RUN with the memory stall removed (redir/lu/normal apply). next = RUN, wcnt <= 0.
  - Release by timeout without ready also sets mem_err=1 until reset.
- A redirect or load-use present during a memory stall is deferred, not lost: EX/ID are frozen and re-evaluated at release.
- stall_cycles increments on every cycle with PC_en=0 and reset high; it holds at 2^CNT_W-1.
- flush_count holds at 255.
- All combinational enables and flushes are forced to 0 while reset is low; dmem_req is also 0.

## Timing
- Reset values: state RUN, wcnt 0, mem_err 0, stall_cycles 0, flush_count 0, wait_state 0.
- Reset asserted mid-MEM_WAIT: immediate return to RUN. The pending access is abandoned and mem_err is not set.
- Zero-wait access: dmem_ready in the same cycle as dmem_req gives no stall.
- An access with N wait cycles (ready on the (N+1)th request cycle) freezes the pipeline for exactly N cycles.
- dmem_req stays high continuously from the first request cycle through the release cycle, and drops the cycle after.
- Load-use costs exactly 1 bubble. Redirect costs 2 squashed slots with no stall.
- Timeout release happens on the cycle where wcnt==TIMEOUT. The worst-case freeze is TIMEOUT cycles.
- Counters and mem_err update on the rising edge following the counted cycle.

## Test plan
- Reset, then ME_MemtoReg=1 with dmem_ready=1, no hazards -> all enables 1, dmem_req=1, stall_cycles stays 0, wait_state 0.
- Load to r5 in EX, ID_rs=5 -> one cycle with PC_en=0, IFID_en=0, IDEX_flush=1; next cycle normal; stall_cycles=1. With EX_WriteReg=0 -> no stall.
- ME store, dmem_ready low 3 cycles then high -> enables 0 for 3 cycles, wait_state=1 for 3 cycles, release on the 4th, stall_cycles=3, mem_err=0.
- EX_PCSrc=3'b010 while lu also true -> IFID_flush=IDEX_flush=1, PC_en=1 (redirect wins), flush_count=1.
- TIMEOUT=4, dmem_ready never high -> frozen 4 cycles, release, mem_err=1 sticky. A later good access keeps mem_err=1 until reset.
- Memory wait with EX_PCSrc!=0 held, ready after 2 cycles -> 2 frozen cycles, then flushes asserted on the release cycle. Separately, assert reset during MEM_WAIT -> state RUN and all outputs at reset values asynchronously.
